// File: rtl/fifo_wr_packer_if.sv
// Narrow valid/ready input stream feeding the FIFO write packer.
interface fifo_wr_packer_if #(
    parameter int unsigned IN_WIDTH = 8
);
    logic                s_valid;
    logic                s_ready;
    logic [IN_WIDTH-1:0] s_data;
    logic                s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/fifo_wr_packer.sv
// Write-side FIFO front end: packs RATIO narrow beats into one wide word and
// writes it into the dual-clock FIFO without ever overflowing it.
module fifo_wr_packer #(
    parameter int unsigned          IN_WIDTH  = 8,
    parameter int unsigned          RATIO     = 4,
    parameter logic [IN_WIDTH-1:0]  PAD_VALUE = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                         rst_n,
    input  logic                         wr_clk,
    fifo_wr_packer_if.slave              s,
    output logic                         fifo_wr_en,
    output logic [IN_WIDTH*RATIO-1:0]    fifo_data,
    input  logic                         fifo_full,
    output logic [CNT_W-1:0]             pkt_cnt
);
    localparam int unsigned DATA_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [DATA_WIDTH-1:0] pk_data;
    logic [LANE_W-1:0]     pk_cnt;
    logic                  pk_full;
    logic                  pk_last;

    logic                  ob_valid;
    logic [DATA_WIDTH-1:0] ob_data;
    logic                  ob_last;

    logic                  accept_c;
    logic                  complete_c;
    logic                  ob_free_c;
    logic [DATA_WIDTH-1:0] word_c;

    // Readiness depends only on the pack register, never on fifo_full.
    assign s.s_ready  = ~pk_full;
    assign fifo_wr_en = ob_valid & ~fifo_full;
    assign fifo_data  = ob_data;

    assign accept_c   = s.s_valid & ~pk_full;
    assign complete_c = accept_c & ((pk_cnt == LANE_W'(RATIO - 1)) | s.s_last);
    assign ob_free_c  = ~ob_valid | fifo_wr_en;

    // Current lane takes the beat; lanes above it are padded on an early last.
    always_comb begin
        word_c = pk_data;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (LANE_W'(i) == pk_cnt) begin
                word_c[i*IN_WIDTH +: IN_WIDTH] = s.s_data;
            end else if ((LANE_W'(i) > pk_cnt) && s.s_last) begin
                word_c[i*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
            end
        end
    end

    // Pack stage.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_data <= '0;
            pk_cnt  <= '0;
            pk_full <= 1'b0;
            pk_last <= 1'b0;
        end else begin
            if (pk_full && ob_free_c) begin
                pk_full <= 1'b0;
            end else if (complete_c && !ob_free_c) begin
                pk_full <= 1'b1;
                pk_last <= s.s_last;
            end
            if (accept_c) begin
                pk_data <= word_c;
                pk_cnt  <= complete_c ? '0 : pk_cnt + LANE_W'(1);
            end
        end
    end

    // Output holding register and packet counter.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_valid <= 1'b0;
            ob_data  <= '0;
            ob_last  <= 1'b0;
            pkt_cnt  <= '0;
        end else begin
            if (pk_full && ob_free_c) begin
                ob_valid <= 1'b1;
                ob_data  <= pk_data;
                ob_last  <= pk_last;
            end else if (complete_c && ob_free_c) begin
                ob_valid <= 1'b1;
                ob_data  <= word_c;
                ob_last  <= s.s_last;
            end else if (fifo_wr_en) begin
                ob_valid <= 1'b0;
            end
            if (fifo_wr_en && ob_last) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer with a behavioural FIFO for the random stream step.
module tb_fifo_wr_packer;
    localparam int unsigned IW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          wr_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_data;
    logic [CW-1:0] pkt_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_wr_packer_if #(.IN_WIDTH(IW)) sif ();

    fifo_wr_packer #(
        .IN_WIDTH (IW),
        .RATIO    (4),
        .PAD_VALUE(8'h00),
        .CNT_W    (CW)
    ) dut (
        .rst_n     (rst_n),
        .wr_clk    (wr_clk),
        .s         (sif.slave),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = l;
        @(negedge wr_clk);
        check("send_ready", 32'(sif.s_ready), 32'd1);
        tick();
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, wr_seen, wr_n, last_wr, gap_bad, rdy_bad;
        int ovf, rd_bad, rd_n, ref_last_n, bcnt;
        logic [31:0] words[$];
        logic [31:0] fq[$];
        logic [31:0] ref_q[$];
        logic [31:0] exp_w, bld, got, want;

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;

        // Reset values
        @(negedge wr_clk);
        check("rst_ready", 32'(sif.s_ready), 32'd1);
        check("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check("rst_data",  fifo_data, 32'h0);
        check("rst_pkt",   32'(pkt_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full word of four beats
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        @(negedge wr_clk);
        check("t1_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t1_data",  fifo_data, 32'h44332211);
        check("t1_pkt",   32'(pkt_cnt), 32'd0);
        tick();
        @(negedge wr_clk);
        check("t1_wr_off", 32'(fifo_wr_en), 32'd0);
        check("t1_pkt2",   32'(pkt_cnt), 32'd0);
        tick();

        // Early last pads the upper lanes
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        @(negedge wr_clk);
        check("t2_wr_en", 32'(fifo_wr_en), 32'd1);
        check("t2_data",  fifo_data, 32'h0000BBAA);
        check("t2_pkt0",  32'(pkt_cnt), 32'd0);
        tick();
        @(negedge wr_clk);
        check("t2_pkt1",  32'(pkt_cnt), 32'd1);
        check("t2_wr_off", 32'(fifo_wr_en), 32'd0);
        tick();

        // Back-pressure: two words buffered, then drained back to back
        fifo_full = 1'b1;
        acc = 0;
        wr_seen = 0;
        for (int c = 0; c < 20; c++) begin
            sif.s_valid = (acc < 12);
            sif.s_data  = 8'(acc + 1);
            sif.s_last  = 1'b0;
            @(negedge wr_clk);
            if (fifo_wr_en) wr_seen++;
            if (sif.s_valid && sif.s_ready) acc++;
            tick();
        end
        sif.s_valid = 1'b0;
        check("t3_accepted", 32'(acc), 32'd8);
        check("t3_no_write", 32'(wr_seen), 32'd0);
        @(negedge wr_clk);
        check("t3_ready_low", 32'(sif.s_ready), 32'd0);
        tick();
        fifo_full = 1'b0;
        @(negedge wr_clk);
        check("t3_wr1_en",   32'(fifo_wr_en), 32'd1);
        check("t3_wr1_data", fifo_data, 32'h04030201);
        tick();
        @(negedge wr_clk);
        check("t3_wr2_en",   32'(fifo_wr_en), 32'd1);
        check("t3_wr2_data", fifo_data, 32'h08070605);
        check("t3_ready_back", 32'(sif.s_ready), 32'd1);
        tick();
        @(negedge wr_clk);
        check("t3_idle", 32'(fifo_wr_en), 32'd0);
        tick();

        // 64 back-to-back beats
        last_wr = -1;
        gap_bad = 0;
        rdy_bad = 0;
        for (int c = 0; c < 68; c++) begin
            sif.s_valid = (c < 64);
            sif.s_data  = 8'(c * 3 + 1);
            sif.s_last  = 1'b0;
            @(negedge wr_clk);
            if (c < 64 && !sif.s_ready) rdy_bad++;
            if (fifo_wr_en) begin
                if (last_wr >= 0 && (c - last_wr) != 4) gap_bad++;
                if (last_wr < 0 && c != 4) gap_bad++;
                last_wr = c;
                words.push_back(fifo_data);
            end
            tick();
        end
        sif.s_valid = 1'b0;
        check("t4_ready", 32'(rdy_bad), 32'd0);
        check("t4_count", 32'(words.size()), 32'd16);
        check("t4_spacing", 32'(gap_bad), 32'd0);
        wr_n = words.size();
        for (int k = 0; k < 16; k++) begin
            exp_w = '0;
            for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'((4 * k + j) * 3 + 1);
            got = (k < wr_n) ? words[k] : 32'hxxxxxxxx;
            check($sformatf("t4_word%0d", k), got, exp_w);
        end
        check("t4_pkt", 32'(pkt_cnt), 32'd1);

        // Reset mid-word discards partial lanes
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        rst_n = 1'b0;
        @(negedge wr_clk);
        check("t5_ready", 32'(sif.s_ready), 32'd1);
        check("t5_wr_en", 32'(fifo_wr_en), 32'd0);
        check("t5_data",  fifo_data, 32'h0);
        check("t5_pkt",   32'(pkt_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b0);
        send(8'hA4, 1'b0);
        @(negedge wr_clk);
        check("t5_wr_en2", 32'(fifo_wr_en), 32'd1);
        check("t5_clean",  fifo_data, 32'hA4A3A2A1);
        tick();

        // Random stream into an 8-deep FIFO drained every third cycle
        ovf = 0; rd_bad = 0; rd_n = 0; ref_last_n = 0; bcnt = 0; bld = '0;
        for (int c = 0; c < 400; c++) begin
            sif.s_valid = (c < 300) && ($urandom_range(0, 3) != 0);
            sif.s_data  = 8'($urandom);
            sif.s_last  = ($urandom_range(0, 4) == 0);
            fifo_full   = (fq.size() >= 8);
            @(negedge wr_clk);
            if (sif.s_valid && sif.s_ready) begin
                bld[bcnt*8 +: 8] = sif.s_data;
                if (sif.s_last || bcnt == 3) begin
                    for (int j = bcnt + 1; j < 4; j++) bld[j*8 +: 8] = 8'h00;
                    ref_q.push_back(bld);
                    if (sif.s_last) ref_last_n++;
                    bcnt = 0;
                end else begin
                    bcnt++;
                end
            end
            if ((c % 3) == 2 && fq.size() > 0) begin
                got  = fq.pop_front();
                want = (ref_q.size() > 0) ? ref_q.pop_front() : 32'hxxxxxxxx;
                if (got !== want) rd_bad++;
                rd_n++;
            end
            if (fifo_wr_en) begin
                if (fifo_full) ovf++;
                fq.push_back(fifo_data);
                if (fq.size() > 8) ovf++;
            end
            tick();
        end
        sif.s_valid = 1'b0;
        fifo_full   = 1'b0;
        check("t6_overflow", 32'(ovf), 32'd0);
        check("t6_read_data", 32'(rd_bad), 32'd0);
        check("t6_drained", 32'(fq.size() + ref_q.size()), 32'd0);
        check("t6_pkt", 32'(pkt_cnt), 32'(ref_last_n));
        check("t6_some_reads", 32'(rd_n > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
